// File: rtl/dpsram_be.sv
// dpsram_be: true dual-port synchronous RAM with per-byte write enables,
// qualified read data (1 or 2 cycle latency) and a post-reset clear sweep.
module dpsram_be #(
    parameter int                    ADDRESS_WIDTH  = 15,
    parameter int                    RAM_SIZE       = 32768,
    parameter int                    WORD_SIZE      = 32,
    parameter int                    BYTE_WIDTH     = 8,
    parameter int                    READ_LATENCY   = 1,
    parameter int                    RDW_NEW        = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [WORD_SIZE-1:0]  CLEAR_VALUE    = '0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    output logic                            ready,
    input  logic [ADDRESS_WIDTH-1:0]        a1,
    input  logic [WORD_SIZE-1:0]            d1,
    input  logic                            wren1,
    input  logic [WORD_SIZE/BYTE_WIDTH-1:0] be1,
    input  logic                            rden1,
    output logic [WORD_SIZE-1:0]            q1,
    output logic                            q1_valid,
    input  logic [ADDRESS_WIDTH-1:0]        a2,
    input  logic [WORD_SIZE-1:0]            d2,
    input  logic                            wren2,
    input  logic [WORD_SIZE/BYTE_WIDTH-1:0] be2,
    input  logic                            rden2,
    output logic [WORD_SIZE-1:0]            q2,
    output logic                            q2_valid
);

    localparam int NBYTES = WORD_SIZE / BYTE_WIDTH;
    localparam int IDX_W  = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
    localparam logic [ADDRESS_WIDTH:0] LIMIT     = (ADDRESS_WIDTH+1)'(RAM_SIZE);
    localparam logic [ADDRESS_WIDTH:0] LAST_ADDR = (ADDRESS_WIDTH+1)'(RAM_SIZE - 1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                   state, state_next;
    logic                     ready_r;
    logic                     sweep_we;
    logic [ADDRESS_WIDTH:0]   sweep_cnt;
    logic [WORD_SIZE-1:0]     mem [RAM_SIZE];

    // Per-port views so both ports share one body of logic; index 1 is port 2.
    logic [ADDRESS_WIDTH-1:0] addr   [2];
    logic [WORD_SIZE-1:0]     wdata  [2];
    logic [NBYTES-1:0]        ben    [2];
    logic [WORD_SIZE-1:0]     rd_word[2];
    logic [WORD_SIZE-1:0]     stg_q  [2];
    logic [WORD_SIZE-1:0]     out_q  [2];
    logic [1:0]               in_range, wr_en, rd_en, stg_v, out_v;

    assign addr[0]  = a1;
    assign addr[1]  = a2;
    assign wdata[0] = d1;
    assign wdata[1] = d2;
    assign ben[0]   = be1;
    assign ben[1]   = be2;

    assign in_range[0] = {1'b0, a1} < LIMIT;
    assign in_range[1] = {1'b0, a2} < LIMIT;
    assign wr_en[0]    = reset_n & ready_r & wren1 & in_range[0];
    assign wr_en[1]    = reset_n & ready_r & wren2 & in_range[1];
    assign rd_en[0]    = ready_r & rden1;
    assign rd_en[1]    = ready_r & rden2;

    assign ready    = ready_r;
    assign q1       = out_q[0];
    assign q2       = out_q[1];
    assign q1_valid = out_v[0];
    assign q2_valid = out_v[1];

    function automatic logic [WORD_SIZE-1:0] merge_bytes(
        input logic [WORD_SIZE-1:0] old_word,
        input logic [WORD_SIZE-1:0] new_word,
        input logic [NBYTES-1:0]    lanes
    );
        logic [WORD_SIZE-1:0] res;
        res = old_word;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (lanes[b]) res[b*BYTE_WIDTH +: BYTE_WIDTH] = new_word[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
        return res;
    endfunction

    // State register: reset lands directly in the sweep (or in RUN when no sweep is wanted).
    always_ff @(posedge clk) begin
        if (!reset_n) state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
        else          state <= state_next;
    end

    // Next state and sweep strobe; the sweep never writes while reset is held.
    always_comb begin
        state_next = state;
        sweep_we   = 1'b0;
        case (state)
            S_CLEAR: begin
                sweep_we = reset_n;
                if (sweep_cnt == LAST_ADDR) state_next = S_RUN;
            end
            S_RUN:   state_next = S_RUN;
            default: state_next = S_CLEAR;
        endcase
    end

    // Registered ready and sweep address counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ready_r   <= 1'b0;
            sweep_cnt <= '0;
        end else begin
            ready_r <= (state_next == S_RUN);
            if (sweep_we) sweep_cnt <= sweep_cnt + 1'b1;
        end
    end

    // Array writes: port 2 lanes are applied after port 1 so they win on collisions.
    always_ff @(posedge clk) begin
        if (sweep_we) mem[sweep_cnt[IDX_W-1:0]] <= CLEAR_VALUE;
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (wr_en[p] && ben[p][b])
                    mem[addr[p][IDX_W-1:0]][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[p][b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Word a read captures: pre-write contents, or the merged word for same-port new-data mode.
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            rd_word[p] = CLEAR_VALUE;
            if (in_range[p]) begin
                if ((RDW_NEW != 0) && wr_en[p])
                    rd_word[p] = merge_bytes(mem[addr[p][IDX_W-1:0]], wdata[p], ben[p]);
                else
                    rd_word[p] = mem[addr[p][IDX_W-1:0]];
            end
        end
    end

    // First read stage: data only updates on a request so it holds between results.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned p = 0; p < 2; p++) stg_q[p] <= '0;
            stg_v <= '0;
        end else begin
            stg_v <= rd_en;
            for (int unsigned p = 0; p < 2; p++) begin
                if (rd_en[p]) stg_q[p] <= rd_word[p];
            end
        end
    end

    generate
        if (READ_LATENCY >= 2) begin : g_lat2
            // Optional output register, again updated only when a result arrives.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    for (int unsigned p = 0; p < 2; p++) out_q[p] <= '0;
                    out_v <= '0;
                end else begin
                    out_v <= stg_v;
                    for (int unsigned p = 0; p < 2; p++) begin
                        if (stg_v[p]) out_q[p] <= stg_q[p];
                    end
                end
            end
        end else begin : g_lat1
            // Single-cycle latency: the first stage drives the outputs directly.
            always_comb begin
                out_v = stg_v;
                for (int unsigned p = 0; p < 2; p++) out_q[p] = stg_q[p];
            end
        end
    endgenerate

endmodule

// File: tb/tb_dpsram_be.sv
// tb_dpsram_be: directed checks of two dpsram_be instances sharing stimulus;
// dut_a uses READ_LATENCY=1/RDW_NEW=0, dut_b uses READ_LATENCY=2/RDW_NEW=1.
module tb_dpsram_be;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  a1, a2;
    logic [31:0] d1, d2;
    logic        wren1, wren2, rden1, rden2;
    logic [3:0]  be1, be2;

    logic        ready_a, ready_b;
    logic [31:0] q1_a, q2_a, q1_b, q2_b;
    logic        q1v_a, q2v_a, q1v_b, q2v_b;

    int unsigned total  = 0;
    int unsigned passes = 0;
    int unsigned fails  = 0;
    logic [31:0] w [4];

    always #5 clk = ~clk;

    dpsram_be #(
        .ADDRESS_WIDTH(5), .RAM_SIZE(16), .WORD_SIZE(32), .BYTE_WIDTH(8),
        .READ_LATENCY(1), .RDW_NEW(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .ready(ready_a),
        .a1(a1), .d1(d1), .wren1(wren1), .be1(be1), .rden1(rden1), .q1(q1_a), .q1_valid(q1v_a),
        .a2(a2), .d2(d2), .wren2(wren2), .be2(be2), .rden2(rden2), .q2(q2_a), .q2_valid(q2v_a)
    );

    dpsram_be #(
        .ADDRESS_WIDTH(5), .RAM_SIZE(16), .WORD_SIZE(32), .BYTE_WIDTH(8),
        .READ_LATENCY(2), .RDW_NEW(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .ready(ready_b),
        .a1(a1), .d1(d1), .wren1(wren1), .be1(be1), .rden1(rden1), .q1(q1_b), .q1_valid(q1v_b),
        .a2(a2), .d2(d2), .wren2(wren2), .be2(be2), .rden2(rden2), .q2(q2_b), .q2_valid(q2v_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input int port, input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] lanes);
        if (port == 1) begin a1 = addr; d1 = data; be1 = lanes; wren1 = 1'b1; end
        else           begin a2 = addr; d2 = data; be2 = lanes; wren2 = 1'b1; end
        tick();
        wren1 = 1'b0;
        wren2 = 1'b0;
    endtask

    // Issues one read and checks both latencies, the one-cycle valid pulse and data hold.
    task automatic do_read(input int port, input logic [4:0] addr, input logic [31:0] exp);
        string t;
        t = $sformatf("p%0d_a%0d", port, addr);
        if (port == 1) begin a1 = addr; rden1 = 1'b1; end
        else           begin a2 = addr; rden2 = 1'b1; end
        tick();
        rden1 = 1'b0;
        rden2 = 1'b0;
        chk({t, "_A_valid"},  32'(port == 1 ? q1v_a : q2v_a), 32'd1);
        chk({t, "_A_q"},      (port == 1 ? q1_a : q2_a), exp);
        chk({t, "_B_early"},  32'(port == 1 ? q1v_b : q2v_b), 32'd0);
        tick();
        chk({t, "_A_pulse"},  32'(port == 1 ? q1v_a : q2v_a), 32'd0);
        chk({t, "_A_hold"},   (port == 1 ? q1_a : q2_a), exp);
        chk({t, "_B_valid"},  32'(port == 1 ? q1v_b : q2v_b), 32'd1);
        chk({t, "_B_q"},      (port == 1 ? q1_b : q2_b), exp);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready_a && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd16);
        chk({tag, "_ready_b"}, 32'(ready_b), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        a1 = '0; a2 = '0; d1 = '0; d2 = '0;
        wren1 = 1'b0; wren2 = 1'b0; rden1 = 1'b0; rden2 = 1'b0;
        be1 = '0; be2 = '0;
        tick();
        tick();
        chk("rst_ready_a", 32'(ready_a), 32'd0);
        chk("rst_q1_a",    q1_a, 32'h0);
        chk("rst_q2_b",    q2_b, 32'h0);
        chk("rst_valid_a", 32'({q1v_a, q2v_a}), 32'd0);
        chk("rst_valid_b", 32'({q1v_b, q2v_b}), 32'd0);

        reset_n = 1'b1;
        wait_ready("sweep1");
        for (int i = 0; i < 16; i++) do_read(1 + (i % 2), 5'(i), 32'h0);

        // Byte-lane merge on port 1, read back on port 2.
        do_write(1, 5'd5, 32'h11223344, 4'b1111);
        do_write(1, 5'd5, 32'hAABBCCDD, 4'b0101);
        do_read(2, 5'd5, 32'h11BB33DD);
        do_write(1, 5'd5, 32'hFFFFFFFF, 4'b0000);
        do_read(2, 5'd5, 32'h11BB33DD);

        // Same-port and cross-port read-during-write at address 3.
        a1 = 5'd3; d1 = 32'hDEADBEEF; be1 = 4'hF; wren1 = 1'b1; rden1 = 1'b1;
        a2 = 5'd3; rden2 = 1'b1;
        tick();
        wren1 = 1'b0; rden1 = 1'b0; rden2 = 1'b0;
        chk("rdw_A_q1",  q1_a, 32'h0);
        chk("rdw_A_q2",  q2_a, 32'h0);
        chk("rdw_A_v",   32'({q1v_a, q2v_a}), 32'd3);
        chk("rdw_B_v0",  32'({q1v_b, q2v_b}), 32'd0);
        tick();
        chk("rdw_B_q1",  q1_b, 32'hDEADBEEF);
        chk("rdw_B_q2",  q2_b, 32'h0);
        chk("rdw_B_v",   32'({q1v_b, q2v_b}), 32'd3);
        do_read(1, 5'd3, 32'hDEADBEEF);

        // Both ports write address 7; port 2 owns the shared lanes.
        a1 = 5'd7; d1 = 32'h01010101; be1 = 4'b1111; wren1 = 1'b1;
        a2 = 5'd7; d2 = 32'h02020202; be2 = 4'b0011; wren2 = 1'b1;
        tick();
        wren1 = 1'b0; wren2 = 1'b0;
        do_read(1, 5'd7, 32'h01010202);

        // Out-of-range write must not alias onto address 4; out-of-range read gives CLEAR_VALUE.
        do_write(1, 5'd20, 32'hFFFFFFFF, 4'b1111);
        do_read(1, 5'd4, 32'h0);
        do_read(2, 5'd20, 32'h0);

        // Back-to-back reads over addresses 0..3.
        for (int i = 0; i < 4; i++) begin
            w[i] = 32'hC0DE0000 | 32'(i * 17 + 1);
            do_write(2, 5'(i), w[i], 4'hF);
        end
        for (int k = 0; k < 6; k++) begin
            a1 = 5'(k);
            rden1 = (k < 4);
            tick();
            chk($sformatf("b2b%0d_A_v", k), 32'(q1v_a), 32'(k < 4));
            chk($sformatf("b2b%0d_A_q", k), q1_a, w[(k < 4) ? k : 3]);
            if (k >= 1) begin
                chk($sformatf("b2b%0d_B_v", k), 32'(q1v_b), 32'(k <= 4));
                chk($sformatf("b2b%0d_B_q", k), q1_b, w[(k - 1 > 3) ? 3 : k - 1]);
            end
        end
        rden1 = 1'b0;

        // Reset in the middle of a sweep restarts it from address 0.
        reset_n = 1'b0;
        tick();
        chk("rst2_q1_a", q1_a, 32'h0);
        chk("rst2_q1_b", q1_b, 32'h0);
        reset_n = 1'b1;
        a1 = 5'd2; d1 = 32'h12345678; be1 = 4'hF; wren1 = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        wren1 = 1'b0;
        chk("mid_ready_a", 32'(ready_a), 32'd0);
        reset_n = 1'b0;
        tick();
        chk("rst3_ready_a", 32'(ready_a), 32'd0);
        reset_n = 1'b1;
        wait_ready("sweep2");
        do_read(1, 5'd2, 32'h0);
        do_read(2, 5'd5, 32'h0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/dpsram_be.md
Name: dpsram_be

Overview:
- Parametrised true dual-port synchronous RAM with per-byte write enables and explicit read enables.
- Qualified read data with selectable 1- or 2-cycle latency, and a selectable same-port read-during-write mode.
- Hardware clear sequencer that sweeps the whole array to a fixed value after reset.
- Used as shared buffer/scratch memory between the control CPU and peripheral logic, where post-reset memory contents must be deterministic.

Parameters:
- ADDRESS_WIDTH, 15, address bits per port.
- RAM_SIZE, 32768, number of words; must satisfy RAM_SIZE <= 2**ADDRESS_WIDTH.
- WORD_SIZE, 32, data bits per word; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per byte lane; NBYTES = WORD_SIZE/BYTE_WIDTH.
- READ_LATENCY, 1, cycles from read request to data: 1 = registered address, 2 = additional output register.
- RDW_NEW, 0, same-port read-during-write: 0 returns old data, 1 returns newly written (byte-merged) data.
- CLEAR_ON_RESET, 1, 1 = sweep array after reset, 0 = ready immediately.
- CLEAR_VALUE, 0, word value written by the sweep.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- ready  out  1  high when the array accepts port operations
- a1  in  ADDRESS_WIDTH  port 1 address
- d1  in  WORD_SIZE  port 1 write data
- wren1  in  1  port 1 write strobe
- be1  in  NBYTES  port 1 byte enables; bit i covers d1[i*BYTE_WIDTH +: BYTE_WIDTH]
- rden1  in  1  port 1 read request
- q1  out  WORD_SIZE  port 1 read data
- q1_valid  out  1  q1 holds data for a request issued READ_LATENCY cycles earlier
- a2, d2, wren2, be2, rden2, q2, q2_valid  same widths and meanings for port 2

Behaviour:
- Reset (reset_n=0 at a clk edge): ready=0, q1=q2=0, q1_valid=q2_valid=0, sweep counter=0.
- Memory contents are not altered by reset itself.
- FSM states:
  - CLEAR: one write of CLEAR_VALUE per cycle at the sweep counter address, counter increments. After the write to RAM_SIZE-1, go to RUN; ready=1 from the following cycle. Total ready latency after reset release = RAM_SIZE cycles.
  - RUN: ready=1; normal port operation.
- Reset exit goes to CLEAR if CLEAR_ON_RESET=1, otherwise to RUN (ready=1 on the first cycle after reset release).
- Reset asserted mid-sweep: the sweep restarts from address 0.
- While ready=0: wren, rden and be inputs on both ports are ignored; no memory write, q_valid stays 0.
- Write: on an edge with ready & wrenN, write byte lane i of dN to mem[aN] only where beN[i]=1. wrenN with beN=0 is a no-op.
- Read: on an edge with ready & rdenN, the address is captured.
  - qN and qN_valid=1 present READ_LATENCY cycles later.
  - qN_valid is a one-cycle pulse per request; back-to-back requests give one result per cycle.
  - qN holds its last value while no new result arrives.
- Same-port read and write in one cycle:
  - RDW_NEW=0: qN returns the pre-write word.
  - RDW_NEW=1: qN returns the stored word after the byte-merge.
- Cross-port: a read on one port of an address the other port writes in the same cycle returns the pre-write word.
- Both ports write the same address in the same cycle: for lanes enabled on both ports, port 2 data wins; lanes enabled on one port only take that port's data.
- Addresses >= RAM_SIZE: writes are dropped; reads return CLEAR_VALUE with qN_valid=1.
- The sweep counter is ADDRESS_WIDTH+1 bits so the terminal compare at RAM_SIZE-1 cannot wrap.

Test Plan:
- Reset 1 cycle then release, CLEAR_ON_RESET=1, RAM_SIZE=16 -> ready rises exactly 16 cycles after release; reads of addresses 0..15 all return CLEAR_VALUE.
- Port 1 writes 0x11223344 to address 5, then writes 0xAABBCCDD with be1=4'b0101, then port 2 reads address 5 -> q2=0x11BB33DD with q2_valid 1 cycle after rden2 at READ_LATENCY=1, 2 cycles after at READ_LATENCY=2.
- Same cycle: port 1 writes 0xDEADBEEF to address 3 (previously 0) with rden1=1 -> q1=0x00000000 at RDW_NEW=0, q1=0xDEADBEEF at RDW_NEW=1; port 2 reading address 3 in that same cycle gets 0x00000000 in both modes.
- Both ports write address 7 in one cycle, d1=0x01010101 be1=4'b1111, d2=0x02020202 be2=4'b0011 -> subsequent read returns 0x01010202.
- Reset asserted 5 cycles into a RAM_SIZE=16 sweep, with a wren1 to address 2 issued during the sweep -> the sweep restarts, ready rises 16 cycles after the second release, and address 2 reads CLEAR_VALUE.
- rden1 held high for 4 consecutive cycles over addresses 0..3 -> q1_valid high for 4 consecutive cycles; q1 returns each word in order; q1 holds the address-3 word after rden1 drops.
